vga_color_arbiter: RTL and testbench

//  Shares the single RGB colour register that feeds the 8-bit VGA DAC among N requesters
//  (switch bank, UART command decoder, pattern generator, ...).

---
 rtl/vga_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/vga_color_arbiter.sv | 145 ++++++++++++++
 tb/tb_vga_color_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA colour path:
//   RGB_W_DEF - default colour word width (8 = 3:3:2 DAC)
//   state_e   - arbiter FSM state encoding
//   clog2     - elaboration-time ceiling log2 for index widths
// Configuration macro used by the consumers of this package: VBLANK_SYNC_EN
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int RGB_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Ceiling log2, at least 1 so index ports never collapse to zero width.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((32'sd1 << res) < value) begin
      res = res + 1;
    end
    if (res < 1) begin
      res = 1;
    end else begin
      res = res;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts at ptr and wraps, so the
// requester at ptr has the highest priority. Masked requesters never win.
// Ports:
//   req  in  N       request vector
//   mask in  N       requesters excluded from this pick
//   ptr  in  PTR_W   first index to consider
//   any  out 1       at least one eligible requester
//   win  out PTR_W   index of the winner (0 when any is low)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] win
);

  logic [N-1:0] elig_s;
  int           idx_s;
  logic         hit_s;

  assign elig_s = req & ~mask;

  // Walk the ring from ptr; the first eligible index seen wins.
  always_comb begin
    any   = 1'b0;
    win   = {PTR_W{1'b0}};
    idx_s = 0;
    hit_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_s = (int'(ptr) + k) % N;
      hit_s = !any && elig_s[idx_s];
      win   = hit_s ? PTR_W'(idx_s) : win;
      any   = any | hit_s;
    end
  end

endmodule

// File: rtl/vga_color_arbiter.sv
// ---------------------------------------------------------------------------
// vga_color_arbiter
// Shares the single RGB colour register feeding the VGA DAC among N_REQ
// requesters. Round-robin arbitration, req/ack commit handshake, and optional
// deferral of each commit to the frame boundary.
// Configuration macro: VBLANK_SYNC_EN
//   defined   - a pending colour commits only on a frame_start pulse seen in PEND
//   undefined - a pending colour commits on the next cycle (fixed 3-cycle latency)
// Ports:
//   clk          in  1             system clock
//   reset_n      in  1             asynchronous active-low reset
//   req          in  N_REQ         per-requester request, held until ack
//   wdata        in  N_REQ*RGB_W   colour words, requester i at [i*RGB_W +: RGB_W]
//   video_on     in  1             visible-area flag from vga_sync
//   frame_start  in  1             1-cycle pulse at start of vertical blanking
//   ack          out N_REQ         one-hot, 1-cycle commit acknowledge
//   gnt_id       out clog2(N_REQ)  current or most recent grantee
//   busy         out 1             FSM not in IDLE
//   rgb          out RGB_W         colour to DAC, zero outside the visible area
// ---------------------------------------------------------------------------
module vga_color_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int RGB_W = RGB_W_DEF,
  localparam int ID_W = clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*RGB_W-1:0] wdata,
  input  logic                   video_on,
  input  logic                   frame_start,
  output logic [N_REQ-1:0]       ack,
  output logic [ID_W-1:0]        gnt_id,
  output logic                   busy,
  output logic [RGB_W-1:0]       rgb
);

  state_e             state_q, state_d;
  logic [RGB_W-1:0]   pend_q, pend_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               busy_q, busy_d;

  logic               rr_any_s;
  logic [ID_W-1:0]    rr_win_s;
  logic               commit_ok_s;

`ifdef VBLANK_SYNC_EN
  assign commit_ok_s = frame_start;
`else
  logic unused_frame_start_s;
  assign unused_frame_start_s = frame_start;
  assign commit_ok_s          = 1'b1;
`endif

  // The requester acked this cycle still shows its stale req; mask it out.
  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (ID_W)
  ) u_rr (
    .req  (req),
    .mask (ack_q),
    .ptr  (ptr_q),
    .any  (rr_any_s),
    .win  (rr_win_s)
  );

  // Next-state and datapath updates for the commit FSM.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    rgb_d    = rgb_q;
    ack_d    = {N_REQ{1'b0}};
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_any_s) begin
          state_d  = ST_PEND;
          pend_d   = wdata[int'(rr_win_s)*RGB_W +: RGB_W];
          gnt_id_d = rr_win_s;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_PEND: begin
        // A withdrawn request beats a simultaneous commit opportunity.
        if (!req[gnt_id_q]) begin
          state_d = ST_IDLE;
        end else if (commit_ok_s) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_PEND;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        rgb_d   = pend_q;
        ack_d   = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_id_q;
        // Grantee drops to lowest priority for the next search.
        if (gnt_id_q == ID_W'(N_REQ-1)) begin
          ptr_d = {ID_W{1'b0}};
        end else begin
          ptr_d = gnt_id_q + ID_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any pending commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      pend_q   <= {RGB_W{1'b0}};
      rgb_q    <= {RGB_W{1'b0}};
      ack_q    <= {N_REQ{1'b0}};
      gnt_id_q <= {ID_W{1'b0}};
      ptr_q    <= {ID_W{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      rgb_q    <= rgb_d;
      ack_q    <= ack_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
    end
  end

  assign ack    = ack_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;
  // Blanking is combinational so the DAC sees no extra pipeline delay.
  assign rgb    = video_on ? rgb_q : {RGB_W{1'b0}};

endmodule

// File: tb/tb_vga_color_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_color_arbiter
// Directed self-checking bench for vga_color_arbiter (N_REQ=4, RGB_W=8).
// Expected commits are queued when a request is driven and popped when ack
// appears. Builds with or without VBLANK_SYNC_EN.
// ---------------------------------------------------------------------------
module tb_vga_color_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] color;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic        video_on;
  logic        frame_start;
  logic [3:0]  ack;
  logic [1:0]  gnt_id;
  logic        busy;
  logic [7:0]  rgb;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] last_rgb;

  vga_color_arbiter #(.N_REQ(4), .RGB_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .wdata       (wdata),
    .video_on    (video_on),
    .frame_start (frame_start),
    .ack         (ack),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .rgb         (rgb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] color);
    exp_t e;
    e.id    = id;
    e.color = color;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for an ack, then compare against the oldest expectation.
  task automatic wait_ack(input string tag, input int budget, output int cyc);
    exp_t e;
    logic found;
    found = 1'b0;
    cyc   = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (ack !== 4'b0000) begin
        found = 1'b1;
        cyc   = i;
        break;
      end
    end
    check({tag, "_ack_seen"}, {31'd0, found}, 32'd1);
    if (found && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_ack"}, {28'd0, ack}, {28'd0, 4'b0001 << e.id});
      check({tag, "_gnt"}, {30'd0, gnt_id}, {30'd0, e.id});
      check({tag, "_rgb"}, {24'd0, rgb}, {24'd0, e.color});
      last_rgb = e.color;
    end
  endtask

  initial begin
    int   cyc;
    logic [1:0] prev;
    logic bad;

    reset_n = 1'b0; req = 4'b0000; wdata = 32'h0000_0000;
    video_on = 1'b1; frame_start = 1'b1; last_rgb = 8'h00;
    tick(); tick();
    check("rst_ack",  {28'd0, ack},    32'd0);
    check("rst_rgb",  {24'd0, rgb},    32'd0);
    check("rst_busy", {31'd0, busy},   32'd0);
    check("rst_gnt",  {30'd0, gnt_id}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: single request, 3-cycle latency, blanking.
    wdata[7:0] = 8'hE0; req = 4'b0001; push(2'd0, 8'hE0);
    wait_ack("single", 10, cyc);
    check("single_lat", cyc, 32'd3);
    req = 4'b0000;
    video_on = 1'b0; #1;
    check("blank_rgb", {24'd0, rgb}, 32'd0);
    video_on = 1'b1; #1;
    check("vis_rgb", {24'd0, rgb}, 32'hE0);
    tick();
    check("ack_one_cycle", {28'd0, ack}, 32'd0);

    // 2: round robin from ptr=0, each drops on its ack.
    reset_n = 1'b0; #1; reset_n = 1'b1;
    wdata = {8'h1F, 8'h03, 8'h1C, 8'hE0};
    req = 4'b1111;
    for (int k = 0; k < 4; k++) push(k[1:0], wdata[k*8 +: 8]);
    prev = 2'd3;
    for (int k = 0; k < 4; k++) begin
      wait_ack("rr", 12, cyc);
      check("rr_lat", cyc, 32'd3);
      if (k > 0) check("rr_no_repeat", {31'd0, gnt_id == prev}, 32'd0);
      prev = gnt_id;
      req = req & ~ack;
    end
    check("rr_all_done", {28'd0, req}, 32'd0);
    tick();

    // 3: frame-synchronised commit for requester 2 (ptr is 0).
    frame_start = 1'b0;
    wdata[23:16] = 8'h55; req = 4'b0100; push(2'd2, 8'h55);
`ifdef VBLANK_SYNC_EN
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy !== 1'b1 || ack !== 4'b0000 || rgb !== last_rgb) bad = 1'b1;
    end
    check("vblank_hold", {31'd0, bad}, 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("vblank_no_early_ack", {28'd0, ack}, 32'd0);
    wait_ack("vblank", 1, cyc);
    check("vblank_lat", cyc, 32'd1);
`else
    bad = 1'b0;
    wait_ack("nosync", 10, cyc);
    check("nosync_lat", cyc, 32'd3);
`endif
    req = 4'b0000;
    tick();

    // 4: move ptr to 1, then abort a request from 1 while pending.
    frame_start = 1'b1;
    wdata[7:0] = 8'h11; req = 4'b0001; push(2'd0, 8'h11);
    wait_ack("pre_abort", 12, cyc);
    req = 4'b0000;
    tick();
    frame_start = 1'b0;
    wdata[15:8] = 8'hAA; req = 4'b0010;
    tick();
    check("abort_busy_pend", {31'd0, busy}, 32'd1);
    check("abort_gnt_pend", {30'd0, gnt_id}, 32'd1);
    req = 4'b0000;
    tick();
    check("abort_idle", {31'd0, busy}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ack !== 4'b0000) bad = 1'b1;
      tick();
    end
    check("abort_no_ack", {31'd0, bad}, 32'd0);
    check("abort_rgb_kept", {24'd0, rgb}, 32'h11);
    check("abort_gnt_kept", {30'd0, gnt_id}, 32'd1);
    frame_start = 1'b1;
    wdata = {8'h44, 8'h33, 8'hAA, 8'h22};
    req = 4'b1111; push(2'd1, 8'hAA);
    wait_ack("after_abort", 12, cyc);
    req = 4'b0000;
    tick(); tick();

    // 5: reset while in COMMIT, then a normal commit.
    wdata[7:0] = 8'h77; req = 4'b0001;
    tick(); tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0; #1;
    check("mid_rst_ack",  {28'd0, ack},    32'd0);
    check("mid_rst_rgb",  {24'd0, rgb},    32'd0);
    check("mid_rst_busy", {31'd0, busy},   32'd0);
    check("mid_rst_gnt",  {30'd0, gnt_id}, 32'd0);
    tick();
    check("mid_rst_no_ack", {28'd0, ack}, 32'd0);
    reset_n = 1'b1;
    push(2'd0, 8'h77);
    wait_ack("post_rst", 10, cyc);
    check("post_rst_lat", cyc, 32'd3);
    req = 4'b0000;
    tick();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
